// File: rtl/apb_mem_slave_p_pkg.sv
// apb_pkg: shared definitions for the parametrised APB4 memory completer.
//   - state_t          : completer FSM states
//   - PPROT_NONSEC_BIT : pprot bit that marks a non-secure access
//   - RESP_OKAY/SLVERR : pslverr encodings
//   - calc_bw/calc_ofs : byte-lane count and byte-offset width for a data width
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int   PPROT_NONSEC_BIT = 1;
    localparam logic RESP_OKAY        = 1'b0;
    localparam logic RESP_SLVERR      = 1'b1;

    function automatic int calc_bw(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int calc_ofs(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_mem_slave_p_if.sv
// apb_if: APB4 bus bundle between a requester (master modport) and a
// completer (slave modport).
//   paddr/pprot/psel/penable/pwrite/pwdata/pstrb : requester -> completer
//   pready/prdata/pslverr                        : completer -> requester
interface apb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic [2:0]          pprot;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_slave_p_bytemem.sv
// apb_bytemem: DEPTH x DATA_W register array.
//   clk, rst_n : clock, asynchronous active-low clear of every word
//   we, widx   : write enable and word index
//   wdata,strb : write data and per-byte lane enables
//   ridx,rdata : combinational read port
module apb_bytemem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strb,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (strb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: APB4 completer backed by a byte-strobed register memory,
// with WAIT_CYCLES pready-low ACCESS cycles and range/alignment/security
// error decode.
//   pclk, presetn : clock, asynchronous active-low reset
//   bus           : APB4 slave modport (paddr..pstrb in; pready/prdata/pslverr out)
module apb_mem_slave_p
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int SECURE_ONLY = 0
) (
    input  logic pclk,
    input  logic presetn,
    apb_if.slave bus
);
    localparam int BW      = calc_bw(DATA_W);
    localparam int OFS     = calc_ofs(DATA_W);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LIMIT_W = ADDR_W + 1;

    localparam logic [3:0]         WAIT_MAX   = 4'(WAIT_CYCLES);
    localparam logic [LIMIT_W-1:0] LIMIT      = LIMIT_W'(DEPTH * BW);
    localparam logic [ADDR_W-1:0]  ALIGN_MASK = ADDR_W'(BW - 1);

    state_t state, state_n;
    logic [3:0] wait_cnt, wait_n;
    logic       latch_en;
    logic       mem_we;

    // Copies of the SETUP-phase request; everything but psel/penable is
    // taken from here during ACCESS.
    logic [ADDR_W-1:0] a_addr;
    logic              a_write;
    logic [DATA_W-1:0] a_wdata;
    logic [BW-1:0]     a_strb;
    logic              a_nonsec;

    logic              err;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
        end
    end

    always_comb begin
        state_n  = state;
        wait_n   = wait_cnt;
        latch_en = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                // psel with penable already high here is a protocol
                // violation and is deliberately ignored.
                if (bus.psel && !bus.penable) begin
                    latch_en = 1'b1;
                    wait_n   = '0;
                    state_n  = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_n = IDLE;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_n = wait_cnt + 4'd1;
                end else if (bus.penable) begin
                    mem_we  = a_write && !err;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (latch_en) begin
            a_addr   <= bus.paddr;
            a_write  <= bus.pwrite;
            a_wdata  <= bus.pwdata;
            a_strb   <= bus.pstrb;
            a_nonsec <= bus.pprot[PPROT_NONSEC_BIT];
        end
    end

    // ALIGN_MASK is zero for 8-bit buses, so the alignment term drops out.
    assign err = ({1'b0, a_addr} >= LIMIT)
              || ((a_addr & ALIGN_MASK) != '0)
              || ((SECURE_ONLY != 0) && a_nonsec);

    assign idx = a_addr[OFS+IDX_W-1:OFS];

    apb_bytemem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (pclk),
        .rst_n (presetn),
        .we    (mem_we),
        .widx  (idx),
        .wdata (a_wdata),
        .strb  (a_strb),
        .ridx  (idx),
        .rdata (rd_word)
    );

    assign bus.pready  = (state == ACCESS) && bus.psel && bus.penable
                      && (wait_cnt == WAIT_MAX);
    assign bus.pslverr = bus.pready ? (err ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
    assign bus.prdata  = (bus.pready && !a_write && !err) ? rd_word : '0;
endmodule

// File: tb/tb_apb_mem_slave_p.sv
// tb_apb_mem_slave_p: directed bench for apb_mem_slave_p. Three instances
// share the request signals and are selected one at a time:
//   u_d0 : default parameters
//   u_d1 : WAIT_CYCLES=3, SECURE_ONLY=1
//   u_d2 : WAIT_CYCLES=2, own reset for the mid-ACCESS reset case
module tb_apb_mem_slave_p;
    logic pclk;
    logic rst_n;
    logic rst2_n;

    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel;

    logic        mready;
    logic        mslverr;
    logic [31:0] mrdata;

    int n_chk;
    int n_fail;

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.paddr = paddr;  assign bus1.paddr = paddr;  assign bus2.paddr = paddr;
    assign bus0.pprot = pprot;  assign bus1.pprot = pprot;  assign bus2.pprot = pprot;
    assign bus0.pwrite = pwrite; assign bus1.pwrite = pwrite; assign bus2.pwrite = pwrite;
    assign bus0.pwdata = pwdata; assign bus1.pwdata = pwdata; assign bus2.pwdata = pwdata;
    assign bus0.pstrb = pstrb;  assign bus1.pstrb = pstrb;  assign bus2.pstrb = pstrb;
    assign bus0.penable = penable; assign bus1.penable = penable; assign bus2.penable = penable;
    assign bus0.psel = psel && (sel == 0);
    assign bus1.psel = psel && (sel == 1);
    assign bus2.psel = psel && (sel == 2);

    apb_mem_slave_p u_d0 (
        .pclk    (pclk),
        .presetn (rst_n),
        .bus     (bus0.slave)
    );

    apb_mem_slave_p #(.WAIT_CYCLES(3), .SECURE_ONLY(1)) u_d1 (
        .pclk    (pclk),
        .presetn (rst_n),
        .bus     (bus1.slave)
    );

    apb_mem_slave_p #(.WAIT_CYCLES(2)) u_d2 (
        .pclk    (pclk),
        .presetn (rst2_n),
        .bus     (bus2.slave)
    );

    always_comb begin
        mready  = bus0.pready;
        mslverr = bus0.pslverr;
        mrdata  = bus0.prdata;
        if (sel == 1) begin
            mready  = bus1.pready;
            mslverr = bus1.pslverr;
            mrdata  = bus1.prdata;
        end else if (sel == 2) begin
            mready  = bus2.pready;
            mslverr = bus2.pslverr;
            mrdata  = bus2.prdata;
        end
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same point.
    // Request inputs are scrambled during ACCESS so only the latched copies
    // can produce the right answer.
    task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, output logic [31:0] rdata,
                            output logic err, output int acc);
        logic got;
        got   = 1'b0;
        rdata = '0;
        err   = 1'b0;
        acc   = 0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        paddr   = ~addr;
        pwdata  = ~data;
        pstrb   = ~strb;
        pwrite  = ~wr;
        pprot   = ~prot;
        while (!got && acc < 40) begin
            #1;
            acc++;
            if (mready) begin
                got   = 1'b1;
                rdata = mrdata;
                err   = mslverr;
            end
            @(posedge pclk);
            #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        if (!got) check({tag, " timeout"}, {63'd0, mready}, 64'd1);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot,
                            input logic exp_err, input int exp_acc);
        logic [31:0] rd;
        logic        e;
        int          acc;
        apb_xfer(tag, 1'b1, addr, data, strb, prot, rd, e, acc);
        check({tag, " pslverr"}, {63'd0, e}, {63'd0, exp_err});
        check({tag, " access cycles"}, 64'(acc), 64'(exp_acc));
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_acc);
        logic [31:0] rd;
        logic        e;
        int          acc;
        apb_xfer(tag, 1'b0, addr, 32'h0, 4'hF, prot, rd, e, acc);
        check({tag, " prdata"}, {32'd0, rd}, {32'd0, exp_data});
        check({tag, " pslverr"}, {63'd0, e}, {63'd0, exp_err});
        check({tag, " access cycles"}, 64'(acc), 64'(exp_acc));
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        sel     = 0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = '0;
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset pready", {63'd0, bus0.pready}, 64'd0);
        check("reset pslverr", {63'd0, bus0.pslverr}, 64'd0);
        check("reset prdata", {32'd0, bus0.prdata}, 64'd0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(posedge pclk);
        #1;

        // zero-wait write then read
        sel = 0;
        do_write("w08", 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 1);
        do_read ("r08", 32'h08, 3'b000, 32'hDEADBEEF, 1'b0, 1);

        // byte strobes
        do_write("w0c full", 32'h0C, 32'h11223344, 4'hF, 3'b000, 1'b0, 1);
        do_write("w0c strb", 32'h0C, 32'hAABBCCDD, 4'b0101, 3'b000, 1'b0, 1);
        do_read ("r0c merged", 32'h0C, 3'b000, 32'h11BB33DD, 1'b0, 1);
        do_write("w0c strb0", 32'h0C, 32'h00000000, 4'h0, 3'b000, 1'b0, 1);
        do_read ("r0c strb0", 32'h0C, 3'b000, 32'h11BB33DD, 1'b0, 1);

        // address errors leave memory alone
        do_write("w04", 32'h04, 32'h55667788, 4'hF, 3'b000, 1'b0, 1);
        do_read ("r80 range", 32'h80, 3'b000, 32'h0, 1'b1, 1);
        do_write("w06 misalign", 32'h06, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b1, 1);
        do_write("w84 range", 32'h84, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b1, 1);
        do_read ("r04 intact", 32'h04, 3'b000, 32'h55667788, 1'b0, 1);

        // penable high with no SETUP is ignored
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h04;
        #1;
        check("violation pready", {63'd0, mready}, 64'd0);
        @(posedge pclk);
        #1;
        check("violation pready after edge", {63'd0, mready}, 64'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        do_read ("r04 after violation", 32'h04, 3'b000, 32'h55667788, 1'b0, 1);

        // wait states and secure-only
        sel = 1;
        do_read ("d1 r00", 32'h00, 3'b000, 32'h0, 1'b0, 4);
        do_write("d1 w10 nonsec", 32'h10, 32'h12345678, 4'hF, 3'b010, 1'b1, 4);
        do_read ("d1 r10 untouched", 32'h10, 3'b000, 32'h0, 1'b0, 4);
        do_write("d1 w10 sec", 32'h10, 32'h12345678, 4'hF, 3'b000, 1'b0, 4);
        do_read ("d1 r10", 32'h10, 3'b000, 32'h12345678, 1'b0, 4);
        do_read ("d1 r10 nonsec", 32'h10, 3'b010, 32'h0, 1'b1, 4);

        // reset during the completing ACCESS cycle of a write
        sel = 2;
        do_write("d2 w08", 32'h08, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, 3);
        do_read ("d2 r08", 32'h08, 3'b000, 32'hCAFEF00D, 1'b0, 3);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'h01020304;
        pstrb   = 4'hF;
        pprot   = 3'b000;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #2;
        check("d2 pready before reset", {63'd0, mready}, 64'd1);
        rst2_n = 1'b0;
        #1;
        check("d2 pready in reset", {63'd0, mready}, 64'd0);
        check("d2 pslverr in reset", {63'd0, mslverr}, 64'd0);
        check("d2 prdata in reset", {32'd0, mrdata}, 64'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        rst2_n = 1'b1;
        @(posedge pclk);
        #1;
        do_read ("d2 r08 after reset", 32'h08, 3'b000, 32'h0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
Parametrised APB4 completer: a byte-strobed register memory with a programmable wait-state count and address/alignment/protection error checking. It replaces the fixed 32x32 APB memory slave as the generic peripheral-memory endpoint behind the APB interconnect. Data width, depth, wait states and secure-only mode are set per instance.

Parameters:
DATA_W, 32, data bus width in bits; must be 8, 16, 32 or 64
ADDR_W, 32, paddr width in bits
DEPTH, 32, number of DATA_W words; a power of two, at least 2
WAIT_CYCLES, 0, pready-low cycles in each ACCESS phase before completion; 0 to 15
SECURE_ONLY, 0, 1 = reject non-secure accesses (pprot[1]=1)

Ports:
pclk  in  1  single clock; all logic on rising edge
presetn  in  1  asynchronous active-low reset
paddr  in  ADDR_W  byte address
pprot  in  3  protection attributes; bit 1 = non-secure
psel  in  1  slave select
penable  in  1  ACCESS-phase indicator
pwrite  in  1  1 = write, 0 = read
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  write byte strobes
pready  out  1  transfer complete
prdata  out  DATA_W  read data; valid when pready=1, pwrite=0 and pslverr=0
pslverr  out  1  error response; valid only while pready=1

Behaviour:
- Reset, asynchronous and entered immediately: state=IDLE, wait_cnt=0, all memory words=0. Outputs go to pready=0, pslverr=0, prdata=0.
- Derived values:
  - BW = DATA_W/8
  - OFS = log2(BW)
  - word index = paddr[OFS+log2(DEPTH)-1 : OFS]
- FSM states:
  - IDLE: when psel=1 and penable=0 (SETUP), latch paddr, pwrite, pwdata, pstrb and pprot; clear wait_cnt; go to ACCESS.
  - ACCESS: if psel=0, abort to IDLE with no write and no response. Else if wait_cnt<WAIT_CYCLES, increment wait_cnt and hold pready=0. Else complete the transfer on this edge and go to IDLE.
- pready = (state==ACCESS) && psel && penable && (wait_cnt==WAIT_CYCLES). It is decoded from registered state, so completion takes exactly WAIT_CYCLES+1 ACCESS cycles. With WAIT_CYCLES=0 the slave is zero-wait.
- Back-to-back transfers: after completion the FSM is in IDLE. A new SETUP in the next cycle is accepted normally, so there is no dead cycle beyond APB's mandatory SETUP.
- psel=1 and penable=1 while the FSM is in IDLE (no preceding SETUP) is a protocol violation. It is ignored: no state change, pready stays 0.
- The error flag err is computed from the latched values. err=1 if any of the following holds:
  - latched paddr >= DEPTH*BW (out of range)
  - latched paddr[OFS-1:0] != 0 (misaligned; not checked when BW=1)
  - SECURE_ONLY=1 and latched pprot[1]=1
- pslverr = pready & err.
- Write completion, pwrite=1 and err=0: for each byte lane b with pstrb[b]=1, mem[idx][8b+7:8b] <= pwdata byte b. Lanes with pstrb[b]=0 are unchanged. pstrb=0 completes with OKAY and leaves memory unchanged.
- Write completion with err=1: memory unchanged.
- Read completion:
  - err=0: prdata = mem[idx] (combinational read of the registered array).
  - err=1: prdata = 0.
  - prdata = 0 whenever pready=0; X is never driven.
- pstrb is ignored on reads.
- A write followed immediately by a read of the same address returns the new data.
- Reset asserted mid-ACCESS: the write is not committed and pready drops asynchronously.
- Inputs changing during ACCESS are ignored because the latched copies are used; only psel and penable are sampled live.

Decomposition:
- Package apb_pkg holds:
  - the state enum typedef (IDLE, ACCESS)
  - constant PPROT_NONSEC_BIT=1
  - localparam helper functions for BW/OFS derivation
  - OKAY/SLVERR response constants
- Sub-module apb_bytemem: DEPTH x DATA_W array with async clear, byte-lane write enable, combinational read port. The top module holds the FSM, wait counter, latches and error decode.

Test Plan:
- Default parameters, write 0xDEADBEEF to 0x08 with pstrb=4'hF, then read 0x08 -> pready high in first ACCESS cycle both times, prdata=0xDEADBEEF, pslverr=0.
- Write 0x11223344 to 0x0C with pstrb=4'hF, then write 0xAABBCCDD with pstrb=4'b0101, then read 0x0C -> prdata=0x11BB33DD.
- WAIT_CYCLES=3, read 0x00 -> pready low for 3 ACCESS cycles and high on the 4th; write/read latency measured = 5 clocks including SETUP.
- Read 0x80 (out of range, DEPTH=32) and write 0x06 (misaligned) -> pslverr=1 with pready=1, prdata=0, memory unchanged; a following read of 0x04 returns the old value.
- SECURE_ONLY=1, write with pprot=3'b010 -> pslverr=1, no update; the same write with pprot=3'b000 succeeds.
- Assert presetn=0 mid-ACCESS of a write with WAIT_CYCLES=2 -> outputs go to 0 immediately, the target word reads 0 after reset, and the FSM is back in IDLE.
